display_7_seg_mux: RTL and testbench
====================================

Name: display_7_seg_mux

Overview:
Parametrised time-multiplexed driver for N common-anode 7-segment digits with per-digit decimal point, blanking and leading-zero suppression. It takes a packed hex-digit bus from the counter/datapath, snapshots it once per scan frame so digits never tear, and drives the SEG/DIGIT board pins directly. It replaces fixed 8-position, 3-value display drivers in all board top levels.

Parameters:
N_DIGITS, 8, number of digit positions scanned; legal range 1..16
TICK_DIV, 50000, clock cycles per digit slot; must be a multiple of 16 and at least 16

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
digits_in  in  4*N_DIGITS  packed hex values; digit k is bits [4k+3:4k]; digit 0 is rightmost
dp_in  in  N_DIGITS  decimal point request per digit; 1 = lit
blank_in  in  N_DIGITS  forced blank per digit; 1 = dark
lzb  in  1  leading-zero blanking enable
SEG  out  8  cathodes, active low; [6:0] = g..a, [7] = DP
DIGIT  out  N_DIGITS  anodes, active low; at most one bit low at any time
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Counters: sub_pre counts 0..TICK_DIV/16-1. On its wrap, phase (4 bits) counts 0..15. On the phase wrap from 15 to 0, posn advances and wraps N_DIGITS-1 -> 0. No unused positions are scanned.
- Timing: slot = TICK_DIV cycles; frame = N_DIGITS*TICK_DIV cycles.
- Snapshot: digits_in, dp_in, blank_in and lzb are registered together in the cycle posn wraps to 0. They are also registered in the first cycle after RST deasserts. Input changes mid-frame have no visible effect until the next frame.
- frame_tick is high for exactly one cycle, coincident with the wrap-driven snapshot load. It is not asserted for the post-reset load.
- Leading-zero blanking (snapshot lzb=1):
  - Digit k is suppressed when every digit from N_DIGITS-1 down to k is 0 and its dp is 0.
  - Digit 0 is never suppressed.
  - A set dp on a digit stops suppression for that digit and every digit below it.
- Dark digit: a digit that is blanked (blank_in or LZB) drives SEG=8'hFF and keeps its DIGIT bit high. dp is also suppressed for a blanked digit.
- Lit digit:
  - SEG[6:0] = hex font of the snapshot value, 0..F.
  - SEG[7] = ~dp.
  - DIGIT = ~(1<<posn).
- Output latency: SEG and DIGIT are registered, one cycle after the counter state that selects them.
- Anti-ghosting: for the first cycle of every slot, DIGIT = all ones, so the old segment data never appears on the new anode.
- Reset (synchronous): SEG=8'hFF, DIGIT=all ones, frame_tick=0, all counters and snapshot registers 0. Reset asserted mid-frame forces all of these values on the next edge regardless of counter state.

Optional Feature:
DISPLAY_BRIGHTNESS_PWM_EN
- Defined: adds input port brightness (4 bits, sampled with the snapshot). The active DIGIT bit is low only while phase <= brightness.
  - brightness=15 gives full duty.
  - brightness=0 gives 1/16 duty.
  - The anti-ghost blank cycle still applies.
- Undefined: no brightness port. The digit is enabled for the whole slot except the anti-ghost cycle.

Decomposition:
- Package display_pkg:
  - SEG_BLANK = 8'hFF
  - 16-entry 7-bit hex font constant table (active low)
  - MAX_DIGITS = 16
- Sub-module seg_font_lut: combinational 4-bit to 7-bit lookup using the package table. Instantiated once and fed by the current-position snapshot nibble.
- Counters, snapshot, LZB and output registers stay in the top.

Test Plan:
1. Reset/first frame: N_DIGITS=4, TICK_DIV=32, digits_in=16'h1234, lzb=0. Hold RST 3 cycles, then release.
   - During RST: SEG=8'hFF, DIGIT=4'hF.
   - Then 32-cycle slots cycle DIGIT 1110,1101,1011,0111 with SEG = font 4,3,2,1.
   - Each slot's first cycle shows DIGIT=4'hF.
2. Wrap/frame_tick: same config.
   - frame_tick pulses exactly once every 128 cycles.
   - There is never more than one low DIGIT bit.
   - posn never exceeds 3.
3. Snapshot: change digits_in to 16'hABCD mid-frame.
   - Remaining slots of that frame still show 1,2,3,4.
   - ABCD appears from the cycle after the next frame_tick.
4. LZB: digits_in=16'h0050, lzb=1, dp_in=0.
   - Digits 3 and 2 are dark; digits 1 and 0 show 5 and 0.
   - With dp_in=4'b0100: digit 2 shows "0." and digit 3 stays dark.
   - With digits_in=16'h0000: only digit 0 is lit, showing 0.
5. Forced blank/mid-run reset: blank_in=4'b0010 gives digit 1 dark (SEG=8'hFF, DIGIT bit 1 high). Asserting RST mid-slot for 1 cycle restores all reset values on the next edge, and scanning restarts at digit 0.
6. PWM (macro defined): brightness=4'd3, TICK_DIV=32 (2 cycles per phase). The anode is low for phases 0..3 minus the first cycle, i.e. 7 of 32 cycles per slot. brightness=15 gives 31 of 32.

Source files
------------

// File: rtl/display_7_seg_mux_pkg.sv
// Shared constants for the multiplexed 7-segment driver: blank pattern,
// digit-count limit and the active-low hex font ([6:0] = g..a).
package display_pkg;

  localparam int         MAX_DIGITS = 16;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Index 15 is listed first, so HEX_FONT[v] selects the glyph for v.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_font_lut.sv
// Combinational hex-nibble to active-low 7-segment glyph lookup.
module seg_font_lut
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_FONT[value];

endmodule

// File: rtl/display_7_seg_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame snapshot,
// blanking and leading-zero suppression. Define DISPLAY_BRIGHTNESS_PWM_EN
// to add the 4-bit brightness input that gates the anode within each slot.
module display_7_seg_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lzb,
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [7:0]            SEG,
  output logic [N_DIGITS-1:0]   DIGIT,
  output logic                  frame_tick
);

  localparam int SUB_DIV = TICK_DIV / 16;
  localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int POSN_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(SUB_DIV - 1);
  localparam logic [POSN_W-1:0] POSN_MAX = POSN_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS || TICK_DIV < 16 || (TICK_DIV % 16) != 0) begin : g_bad_param
    $error("display_7_seg_mux: illegal N_DIGITS or TICK_DIV");
  end

  logic [SUB_W-1:0]      sub_pre;
  logic [3:0]            phase;
  logic [POSN_W-1:0]     posn;
  logic                  load_pending;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_blank;
  logic                  snap_lzb;
  logic                  pwm_on;

`ifdef DISPLAY_BRIGHTNESS_PWM_EN
  logic [3:0] snap_bright;
  assign pwm_on = (phase <= snap_bright);
`else
  assign pwm_on = 1'b1;
`endif

  logic sub_wrap, frame_wrap, slot_start;
  assign sub_wrap   = (sub_pre == SUB_MAX);
  assign frame_wrap = sub_wrap && (phase == 4'hF) && (posn == POSN_MAX);
  assign slot_start = (sub_pre == '0) && (phase == 4'h0);

  // A digit is suppressed while it and every digit above it are zero with
  // no decimal point; digit 0 always stays lit.
  logic [N_DIGITS-1:0] lz_sup;
  always_comb begin
    logic run;
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned (which would infer a latch).
    run    = 1'b1;
    lz_sup = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run       = run & (snap_digits[4*k +: 4] == 4'h0) & ~snap_dp[k];
      lz_sup[k] = (k != 0) && run && snap_lzb;
    end
  end

  logic [3:0]          cur_nib;
  logic [6:0]          font_seg;
  logic                dark;
  logic [N_DIGITS-1:0] anode_sel;

  assign cur_nib   = snap_digits[{posn, 2'b00} +: 4];
  assign dark      = snap_blank[posn] | lz_sup[posn];
  assign anode_sel = N_DIGITS'(1) << posn;

  seg_font_lut u_font (
    .value (cur_nib),
    .seg_n (font_seg)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (RST) begin
      sub_pre      <= '0;
      phase        <= '0;
      posn         <= '0;
      load_pending <= 1'b1;
      // NOTE: the snapshot is a handful of flops, not a memory, so it is
      // cleared with everything else.
      snap_digits  <= '0;
      snap_dp      <= '0;
      snap_blank   <= '0;
      snap_lzb     <= 1'b0;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
      snap_bright  <= '0;
`endif
      SEG          <= SEG_BLANK;
      DIGIT        <= '1;
      frame_tick   <= 1'b0;
    end else begin
      load_pending <= 1'b0;
      frame_tick   <= frame_wrap;

      if (sub_wrap) begin
        sub_pre <= '0;
        phase   <= phase + 4'd1;
        if (phase == 4'hF)
          posn <= (posn == POSN_MAX) ? '0 : posn + 1'b1;
      end else begin
        sub_pre <= sub_pre + 1'b1;
      end

      if (load_pending || frame_wrap) begin
        snap_digits <= digits_in;
        snap_dp     <= dp_in;
        snap_blank  <= blank_in;
        snap_lzb    <= lzb;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
        snap_bright <= brightness;
`endif
      end

      // First cycle of each slot keeps all anodes off to avoid ghosting.
      DIGIT <= (slot_start || dark || !pwm_on) ? '1 : ~anode_sel;
      SEG   <= (load_pending || dark) ? SEG_BLANK : {~snap_dp[posn], font_seg};
    end
  end

endmodule

// File: tb/tb_display_7_seg_mux.sv
// Directed scoreboard bench for display_7_seg_mux (4 digits, 32-cycle slots).
module tb_display_7_seg_mux;

  localparam int N     = 4;
  localparam int TD    = 32;
  localparam int FRAME = N * TD;

  logic           CLK = 1'b0;
  logic           RST;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   blank_in;
  logic           lzb;
  logic [3:0]     bright;
  logic [7:0]     SEG;
  logic [N-1:0]   DIGIT;
  logic           frame_tick;

  always #5 CLK = ~CLK;

  display_7_seg_mux #(.N_DIGITS(N), .TICK_DIV(TD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lzb        (lzb),
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    .brightness (bright),
`endif
    .SEG        (SEG),
    .DIGIT      (DIGIT),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] digit;
    logic         ft;
    logic         seg_valid;
  } exp_t;

  // Active-high gfedcba glyphs; the display drives the inverse.
  localparam logic [6:0] FONT_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             k      = 0;
  int             low0   = 0;
  logic [4*N-1:0] s_dig;
  logic [N-1:0]   s_dp, s_blank;
  logic           s_lzb;
  logic [3:0]     s_bright;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, expv, k);
    end
  endtask

  function automatic logic lz_dark(input int slot);
    if (!s_lzb || slot == 0) return 1'b0;
    for (int j = slot; j < N; j++)
      if (s_dig[4*j +: 4] != 4'h0 || s_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model(input int kk, input logic in_rst);
    exp_t         e;
    int           off, slot, ph;
    logic         dk;
    logic [N-1:0] one;
    one = 1;
    e   = '{seg: 8'hFF, digit: '1, ft: 1'b0, seg_valid: 1'b1};
    if (in_rst || kk == 0) return e;
    off   = kk % TD;
    slot  = (kk / TD) % N;
    ph    = off / (TD / 16);
    e.ft  = (kk % FRAME) == (FRAME - 1);
    dk    = s_blank[slot] || lz_dark(slot);
    e.digit     = (off == 0 || dk || ph > int'(s_bright)) ? '1 : ~(one << slot);
    e.seg       = dk ? 8'hFF : {~s_dp[slot], ~FONT_ON[s_dig[4*slot +: 4]]};
    e.seg_valid = (off != 0);
    return e;
  endfunction

  task automatic step();
    exp_t e;
    sb.push_back(model(k, RST));
    if (!RST && (k == 0 || (k % FRAME) == FRAME - 1)) begin
      s_dig   = digits_in;
      s_dp    = dp_in;
      s_blank = blank_in;
      s_lzb   = lzb;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
      s_bright = bright;
`else
      s_bright = 4'hF;
`endif
    end
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("DIGIT", 8'(DIGIT), 8'(e.digit));
    check("frame_tick", 8'(frame_tick), 8'(e.ft));
    if (e.seg_valid) check("SEG", SEG, e.seg);
    if (!RST && (k % FRAME) < TD && DIGIT[0] == 1'b0) low0++;
    k = RST ? 0 : k + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    run(n);
    RST = 1'b0;
    k   = 0;
  endtask

  initial begin
    RST       = 1'b1;
    digits_in = 16'h1234;
    dp_in     = '0;
    blank_in  = '0;
    lzb       = 1'b0;
    bright    = 4'hF;
    s_dig = '0; s_dp = '0; s_blank = '0; s_lzb = 1'b0; s_bright = 4'hF;

    // Reset, first frame, wrap and frame_tick.
    do_reset(3);
    run(192);

    // Mid-frame change: visible only after the next frame_tick.
    digits_in = 16'hABCD;
    run(192);

    // Leading-zero blanking cases.
    digits_in = 16'h0050; lzb = 1'b1; dp_in = 4'b0000;
    run(256);
    dp_in = 4'b0100;
    run(256);
    digits_in = 16'h0000; dp_in = 4'b0000;
    run(256);

    // Forced blank, then a one-cycle reset in the middle of a slot.
    digits_in = 16'h1234; lzb = 1'b0; blank_in = 4'b0010;
    run(200);
    do_reset(1);
    run(160);
    blank_in = '0;

`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    bright = 4'd3;
    do_reset(2);
    low0 = 0;
    run(FRAME);
    check("pwm_low_b3", 8'(low0), 8'd7);
    bright = 4'd15;
    do_reset(2);
    low0 = 0;
    run(FRAME);
    check("pwm_low_b15", 8'(low0), 8'd31);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
